// File: rtl/int_div_iter_if.sv
// int_div_iter_if: request/response stream bundle for the iterative divider
interface int_div_iter_if #(parameter int NBITS = 32);
  logic               istream_val;
  logic               istream_rdy;
  logic [2*NBITS-1:0] istream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [2*NBITS-1:0] ostream_msg;
  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );
  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/int_div_iter.sv
// int_div_iter: iterative restoring divider, one quotient bit per cycle; define INT_DIV_ITER_SIGNED_EN for two's-complement operands
module int_div_iter #(parameter int NBITS = 32) (
  input logic          clk,
  input logic          reset,
  int_div_iter_if.slave io
);
  localparam int CW = NBITS > 1 ? $clog2(NBITS) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state;
  logic               rdy, val;
  logic [2*NBITS-1:0] msg;
  logic [CW-1:0]      cnt;
  logic [NBITS-1:0]   dvd, dvs, rem, a, b, a_mag, b_mag, q_nxt, r_nxt, q_out, r_out;
  logic [NBITS:0]     sh;
  logic               ge;
`ifdef INT_DIV_ITER_SIGNED_EN
  logic               neg_q, neg_r;
`endif
  assign a = io.istream_msg[2*NBITS-1:NBITS];
  assign b = io.istream_msg[NBITS-1:0];
  assign io.istream_rdy = rdy;
  assign io.ostream_val = val;
  assign io.ostream_msg = msg;
  // restoring step: the dividend register doubles as the quotient shift register
  always_comb begin
    sh    = {rem, dvd[NBITS-1]};
    ge    = sh >= {1'b0, dvs};
    r_nxt = ge ? NBITS'(sh - {1'b0, dvs}) : sh[NBITS-1:0];
    q_nxt = (dvd << 1) | NBITS'(ge);
  end
`ifdef INT_DIV_ITER_SIGNED_EN
  assign a_mag = a[NBITS-1] ? -a : a;
  assign b_mag = b[NBITS-1] ? -b : b;
  assign q_out = neg_q ? -q_nxt : q_nxt;
  assign r_out = neg_r ? -r_nxt : r_nxt;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_out = q_nxt;
  assign r_out = r_nxt;
`endif
  // control FSM and datapath; rdy/val mirror the state so outputs come straight from flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rdy   <= 1'b0;
      val   <= 1'b0;
      msg   <= '0;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
`ifdef INT_DIV_ITER_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (io.istream_val && rdy) begin
            rdy <= 1'b0;
            cnt <= '0;
            rem <= '0;
            dvd <= a_mag;
            dvs <= b_mag;
`ifdef INT_DIV_ITER_SIGNED_EN
            neg_q <= a[NBITS-1] ^ b[NBITS-1];
            neg_r <= a[NBITS-1];
`endif
            if (b == '0) begin
              state <= DONE;
              val   <= 1'b1;
              msg   <= {{NBITS{1'b1}}, a};
            end else
              state <= CALC;
          end else
            rdy <= 1'b1;
        CALC: begin
          dvd <= q_nxt;
          rem <= r_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NBITS - 1)) begin
            state <= DONE;
            val   <= 1'b1;
            msg   <= {q_out, r_out};
          end
        end
        DONE:
          if (val && io.ostream_rdy) begin
            state <= IDLE;
            val   <= 1'b0;
            rdy   <= 1'b1;
          end
        default: begin
          state <= IDLE;
          val   <= 1'b0;
          rdy   <= 1'b1;
        end
      endcase
endmodule
